// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store initiator: access-size codes,
// FSM state encoding, the default memory depth and a lane-shift helper.
package mem_access_unit_pkg;

   localparam int MEM_WORDS_DEFAULT = 256;

   // Access size codes carried on req_size
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   // FSM state encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_STORE  = 3'd2;
   localparam logic [2:0] ST_RMW_RD = 3'd3;
   localparam logic [2:0] ST_RMW_WR = 3'd4;
   localparam logic [2:0] ST_RESP   = 3'd5;

   // Right-shift that brings a big-endian lane down to bit 0.
   // Byte offset o sits at bits [31-8o -: 8], so the shift is (3-o)*8;
   // halfword offset 0 sits at [31:16] (shift 16), offset 2 at [15:0].
   function automatic logic [4:0] lane_shift(input logic [1:0] offset,
                                             input logic [1:0] size);
      logic [4:0] sh;
      sh = 5'd0;
      case (size)
         SZ_BYTE: sh = {~offset, 3'b000};
         SZ_HALF: sh = {~offset[1], 4'b0000};
         default: sh = 5'd0;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane handling for big-endian sub-word accesses:
// extracts and extends a load lane, and merges store data into an old word.
module lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] new_data,
   output logic [31:0] ext_data,
   output logic [31:0] merged
);

   logic [4:0]  shift;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] lane_mask;
   logic [31:0] mask;

   assign shift = lane_shift(offset, size);

   // Extract the addressed lane and sign- or zero-extend it to 32 bits
   always_comb begin
      byte_lane = 8'(word >> shift);
      half_lane = 16'(word >> shift);
      ext_data  = 32'h0;
      case (size)
         SZ_BYTE: ext_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
         SZ_HALF: ext_data = {{16{sign_ext & half_lane[15]}}, half_lane};
         SZ_WORD: ext_data = word;
         default: ext_data = 32'h0;
      endcase
   end

   // Replace only the addressed lane of the old word with right-aligned new data
   always_comb begin
      lane_mask = 32'h0;
      case (size)
         SZ_BYTE: lane_mask = 32'h0000_00FF;
         SZ_HALF: lane_mask = 32'h0000_FFFF;
         SZ_WORD: lane_mask = 32'hFFFF_FFFF;
         default: lane_mask = 32'h0;
      endcase
      mask   = lane_mask << shift;
      merged = (word & ~mask) | ((new_data << shift) & mask);
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the CPU MEM stage and a word-addressed data
// memory. Byte/halfword stores are done as read-modify-write; loads return
// extended lane data; bad requests are answered with resp_err and never
// touch the memory.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only while idle, and the request
// fields are captured on that edge only. resp_valid is a single-cycle
// pulse with no backpressure; resp_rdata/resp_err are valid with it.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
   parameter int ADDR_W    = 32
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_ReadMem,
   output logic              mem_WriteMem,
   output logic [ADDR_W-1:0] mem_Addr,
   output logic [31:0]       mem_wData,
   input  logic [31:0]       mem_rData,
   output logic [2:0]        fsm_state
);

   logic [2:0]        state;
   logic [1:0]        lat_size;
   logic              lat_signed;
   logic [1:0]        lat_off;
   logic [31:0]       lat_wdata;

   logic [ADDR_W-1:0] word_idx;
   logic              acc_err;
   logic [31:0]       ext_data;
   logic [31:0]       merged;

   // Request checks evaluated on the incoming request so the error is known at acceptance
   always_comb begin
      word_idx = {2'b00, req_addr[ADDR_W-1:2]};
      acc_err  = 1'b0;
      if (req_size == SZ_HALF && req_addr[0])          acc_err = 1'b1;
      if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) acc_err = 1'b1;
      if (req_size == SZ_RSVD)                         acc_err = 1'b1;
      if (word_idx >= ADDR_W'(MEM_WORDS))              acc_err = 1'b1;
   end

   lane_align u_lane_align (
      .word     (mem_rData),
      .offset   (lat_off),
      .size     (lat_size),
      .sign_ext (lat_signed),
      .new_data (lat_wdata),
      .ext_data (ext_data),
      .merged   (merged)
   );

   // Main access FSM plus captured request and response registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         lat_size   <= SZ_BYTE;
         lat_signed <= 1'b0;
         lat_off    <= 2'b00;
         lat_wdata  <= 32'h0;
         mem_Addr   <= '0;
         mem_wData  <= 32'h0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  lat_size   <= req_size;
                  lat_signed <= req_signed;
                  lat_off    <= req_addr[1:0];
                  lat_wdata  <= req_wdata;
                  mem_Addr   <= word_idx;
                  resp_rdata <= 32'h0;
                  resp_err   <= acc_err;
                  if (acc_err) begin
                     state <= ST_RESP;
                  end else if (!req_write) begin
                     state <= ST_LOAD;
                  end else if (req_size == SZ_WORD) begin
                     mem_wData <= req_wdata;
                     state     <= ST_STORE;
                  end else begin
                     state <= ST_RMW_RD;
                  end
               end
            end
            ST_LOAD: begin
               resp_rdata <= ext_data;
               state      <= ST_RESP;
            end
            ST_STORE:  state <= ST_RESP;
            ST_RMW_RD: begin
               mem_wData <= merged;
               state     <= ST_RMW_WR;
            end
            ST_RMW_WR: state <= ST_RESP;
            ST_RESP:   state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   // Enables are gated by rst_n so a reset edge can never commit a write
   assign mem_ReadMem  = rst_n & ((state == ST_LOAD)  | (state == ST_RMW_RD));
   assign mem_WriteMem = rst_n & ((state == ST_STORE) | (state == ST_RMW_WR));
   assign req_ready    = (state == ST_IDLE);
   assign resp_valid   = (state == ST_RESP);
   assign fsm_state    = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ReadMem;
  logic        mem_WriteMem;
  logic [31:0] mem_Addr;
  logic [31:0] mem_wData;
  logic [31:0] mem_rData;
  logic [2:0]  fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  int en_cnt = 0;
  logic [31:0] exp_q[$];

  logic [31:0] mem [0:255];
  bit mem_init = 1'b0;

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_ReadMem  (mem_ReadMem),
    .mem_WriteMem (mem_WriteMem),
    .mem_Addr     (mem_Addr),
    .mem_wData    (mem_wData),
    .mem_rData    (mem_rData),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  // memory model
  function automatic logic [31:0] init_val(input int i);
    if (i >= 50 && i < 60) return 32'(i - 50);
    if (i == 101) return 32'h1122_3344;
    if (i == 255) return 32'hCAFE_F00D;
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (mem_WriteMem && mem_Addr < 32'd256) begin
      mem[mem_Addr[7:0]] <= mem_wData;
    end
  end

  assign mem_rData = (mem_ReadMem && mem_Addr < 32'd256) ? mem[mem_Addr[7:0]] : 32'h0;

  always @(negedge clk) if (mem_ReadMem || mem_WriteMem) en_cnt++;

  // checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver: one request, called at a negedge; returns at the negedge of the response cycle
  task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rdata, output logic err, output int lat);
    int budget;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    budget = 0;
    while (!req_ready && budget < 20) begin
      @(posedge clk); @(negedge clk); budget++;
    end
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~wr; req_size = 2'b11; req_signed = ~sg;
    req_addr = 32'hFFFF_FFFC; req_wdata = $urandom;
    rdata = 32'h0; err = 1'b0; lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (resp_valid) begin
        rdata = resp_rdata; err = resp_err;
        break;
      end
    end
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] exp_data);
    logic [31:0] rd; logic er; int lat;
    run_req(1'b0, sz, sg, addr, 32'h0, rd, er, lat);
    check({tag, "_data"}, rd, exp_data);
    check({tag, "_err"}, 32'(er), 32'd0);
    check({tag, "_lat"}, 32'(lat), 32'd2);
  endtask

  task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input int exp_lat,
                          input int word, input logic [31:0] exp_word);
    logic [31:0] rd; logic er; int lat;
    run_req(1'b1, sz, 1'b0, addr, wd, rd, er, lat);
    check({tag, "_rdata"}, rd, 32'h0);
    check({tag, "_err"}, 32'(er), 32'd0);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_mem"}, mem[word], exp_word);
  endtask

  task automatic do_err(input string tag, input logic wr, input logic [1:0] sz,
                        input logic [31:0] addr);
    logic [31:0] rd; logic er; int lat; int en_before;
    en_before = en_cnt;
    run_req(wr, sz, 1'b0, addr, 32'h5555_AAAA, rd, er, lat);
    check({tag, "_err"}, 32'(er), 32'd1);
    check({tag, "_rdata"}, rd, 32'h0);
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_no_mem_en"}, 32'(en_cnt - en_before), 32'd0);
  endtask

  // main sequence
  initial begin
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_exp  [3];
    int n_acc, n_resp, cyc, last_resp_cyc;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_addr", mem_Addr, 32'h0);
    check("rst_mem_wdata", mem_wData, 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_en", 32'({mem_ReadMem, mem_WriteMem}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // word loads from preloaded region and the top word
    do_load("ld_w200", 2'b10, 1'b0, 32'd200, 32'h0000_0000);
    do_load("ld_w236", 2'b10, 1'b0, 32'd236, 32'h0000_0009);
    do_load("ld_w1020", 2'b10, 1'b0, 32'd1020, 32'hCAFE_F00D);

    // word store then sub-word loads
    do_store("st_w400", 2'b10, 32'd400, 32'hDEAD_BEEF, 2, 100, 32'hDEAD_BEEF);
    do_load("ld_bs400", 2'b00, 1'b1, 32'd400, 32'hFFFF_FFDE);
    do_load("ld_hu402", 2'b01, 1'b0, 32'd402, 32'h0000_BEEF);
    do_load("ld_hs402", 2'b01, 1'b1, 32'd402, 32'hFFFF_BEEF);
    do_load("ld_bu403", 2'b00, 1'b0, 32'd403, 32'h0000_00EF);
    do_load("ld_bs402", 2'b00, 1'b1, 32'd402, 32'hFFFF_FFBE);

    // partial stores via read-modify-write
    do_store("st_b401", 2'b00, 32'd401, 32'hFFFF_FF5A, 3, 100, 32'hDE5A_BEEF);
    do_store("st_h402", 2'b01, 32'd402, 32'hABCD_1234, 3, 100, 32'hDE5A_1234);
    do_load("ld_hs400", 2'b01, 1'b1, 32'd400, 32'hFFFF_DE5A);
    do_load("ld_w400", 2'b10, 1'b0, 32'd400, 32'hDE5A_1234);

    // error cases
    do_err("err_w202", 1'b0, 2'b10, 32'd202);
    do_err("err_w1024", 1'b0, 2'b10, 32'd1024);
    do_err("err_rsvd", 1'b0, 2'b11, 32'd200);
    do_err("err_h401", 1'b0, 2'b01, 32'd401);
    do_err("err_st1024", 1'b1, 2'b10, 32'd1024);

    // reset during RMW_WR must suppress the write
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'd405; req_wdata = 32'h0000_00AA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstwr_state_rd", 32'(fsm_state), 32'd3);
    @(negedge clk);
    check("rstwr_state_wr", 32'(fsm_state), 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstwr_mem", mem[101], 32'h1122_3344);
    check("rstwr_state", 32'(fsm_state), 32'd0);
    check("rstwr_ready", 32'(req_ready), 32'd1);
    check("rstwr_resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // back-to-back loads with req_valid held high and req_addr changing
    b2b_addr[0] = 32'd204; b2b_exp[0] = 32'd1;
    b2b_addr[1] = 32'd208; b2b_exp[1] = 32'd2;
    b2b_addr[2] = 32'd212; b2b_exp[2] = 32'd3;
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    n_acc = 0; n_resp = 0; cyc = 0; last_resp_cyc = -1;
    while (n_resp < 3 && cyc < 40) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) check("b2b_unexpected_resp", 32'd1, 32'd0);
        else check("b2b_data", resp_rdata, exp_q.pop_front());
        n_resp++;
        last_resp_cyc = cyc;
      end
      if (req_ready && n_acc < 3) begin
        req_valid = 1'b1;
        req_addr = b2b_addr[n_acc];
        exp_q.push_back(b2b_exp[n_acc]);
        n_acc++;
      end else begin
        req_valid = (n_acc < 3);
        req_addr = 32'd232;
      end
      @(posedge clk); @(negedge clk); cyc++;
    end
    req_valid = 1'b0;
    check("b2b_resp_count", 32'(n_resp), 32'd3);
    check("b2b_last_resp_cycle", 32'(last_resp_cyc), 32'd8);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store initiator that sits between the CPU MEM stage and the word-addressed data memory. It accepts byte-addressed load and store requests over a valid/ready handshake and drives the memory's ReadMem/WriteMem/Addr/wData/rData interface. Partial-word stores are performed as read-modify-write sequences. The block returns sign- or zero-extended load data, plus an error flag for misaligned or out-of-range accesses.

Parameters:
MEM_WORDS, 256, number of 32-bit words in the data memory; word index must be < MEM_WORDS
ADDR_W, 32, width of request and memory address buses

Ports:
clk  in  1  system clock, all state changes on posedge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  valid with resp_valid: misaligned, out-of-range or reserved size
mem_ReadMem  out  1  memory read enable
mem_WriteMem  out  1  memory write enable
mem_Addr  out  ADDR_W  word index = latched byte address >> 2
mem_wData  out  32  word to write
mem_rData  in  32  combinational read data, valid while mem_ReadMem=1

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_Addr=0, mem_wData=0.
- mem_ReadMem and mem_WriteMem are combinationally ANDed with rst_n. No memory write may occur on an edge where rst_n=0, including reset in the middle of a store.
- req_ready=1 only in IDLE. A handshake (req_valid & req_ready) latches write, size, signed, addr and wdata. Later changes on the req_* inputs are ignored.
- Byte lanes are big-endian: offset 0 = bits[31:24], offset 3 = [7:0]. Halfword offset 0 = [31:16], offset 2 = [15:0].
- Error checks run at acceptance:
  - halfword with addr[0]=1 is an error;
  - word with addr[1:0]!=0 is an error;
  - size 11 is an error;
  - (addr>>2) >= MEM_WORDS is an error.
  - An erroring request goes to RESP with resp_err=1 and no memory enable asserted.
- FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
  - IDLE -> LOAD (load), STORE (word store), RMW_RD (byte/half store), or RESP (error).
  - LOAD: mem_ReadMem=1. At the edge, extract the lane from mem_rData, extend it and register into the result. -> RESP.
  - STORE: mem_WriteMem=1, mem_wData=wdata. -> RESP.
  - RMW_RD: mem_ReadMem=1. Merge the new byte/half into mem_rData at the lane and register it into mem_wData. -> RMW_WR.
  - RMW_WR: mem_WriteMem=1. -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, no backpressure. -> IDLE.
- Latency from the accept edge to the resp_valid cycle:
  - load / word store: 2 cycles;
  - partial store: 3 cycles;
  - error: 1 cycle.
- Back-to-back throughput: a new request can be accepted the cycle after RESP.
- mem_Addr stays constant for the whole access. In IDLE, both memory enables are 0 and mem_Addr holds its last value.

Decomposition:
- Shared package holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - FSM state encoding;
  - MEM_WORDS default.
- One combinational sub-module, lane_align, provides two functions:
  - extract+extend: word, offset, size, signed -> 32b;
  - merge: old word, new data, offset, size -> 32b.

Test Plan:
- Memory words 50..59 preloaded 0..9. Load word at byte addr 200 -> resp_valid 2 cycles after accept, resp_rdata=0x00000000. Load word at 236 -> 0x00000009.
- Word store 0xDEADBEEF at addr 400, then load byte signed at 400 -> 0xFFFFFFDE. Load half unsigned at 402 -> 0x0000BEEF.
- Byte store 0x5A at addr 401 over 0xDEADBEEF -> RMW_RD then RMW_WR. Word 100 then reads 0xDE5ABEEF, and resp arrives 3 cycles after accept.
- Word load at addr 202 -> resp_err=1 one cycle after accept, resp_rdata=0, mem enables never asserted. Word load at addr 1024 (word 256) -> resp_err=1.
- rst_n=0 during RMW_WR -> no write (word unchanged), next cycle IDLE, req_ready=1, resp_valid=0.
- req_valid held high for 3 back-to-back loads with changing req_addr -> each accept only when req_ready=1, results in order, inputs sampled only at accept.
